// File: rtl/alu_mc.sv
// Handshaked ALU with registered result/flags and IDLE/BUSY/DONE control.
// Optional shift-add multiplier (opcode 1010) is compiled in by defining ALU_MC_MUL_EN.
module alu_mc #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] data1,
    input  logic [N-1:0] data2,
    input  logic [3:0]   ALU_Select,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         carry,
    output logic         overflow
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpPass = 4'b0111;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSltu = 4'b1001;

`ifdef ALU_MC_MUL_EN
    localparam logic [3:0]  OpMul = 4'b1010;
    localparam int unsigned CntW  = $clog2(N);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
    typedef enum logic [0:0] {StIdle, StDone} state_e;
`endif

    state_e       state_q, state_d;
    logic [N-1:0] result_q, result_d;
    logic         zero_q, zero_d;
    logic         carry_q, carry_d;
    logic         overflow_q, overflow_d;

    logic         accept;
    logic [N:0]   sum;
    logic [N-1:0] diff;
    logic [N-1:0] alu_res;
    logic         alu_zero;
    logic         alu_carry;
    logic         alu_ovf;

`ifdef ALU_MC_MUL_EN
    // {hi, lo} is the running product; lo starts as the multiplier and shifts out LSB-first
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N:0]      mul_sum;
    logic [N-1:0]    mul_hi_nx;
    logic [N-1:0]    mul_lo_nx;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(N + 1){1'b0}});
        mul_hi_nx = mul_sum[N:1];
        mul_lo_nx = {mul_sum[0], lo_q[N-1:1]};
    end
`endif

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;

    // Single-cycle operations, evaluated on the live request inputs
    always_comb begin
        sum       = {1'b0, data1} + {1'b0, data2};
        diff      = data1 - data2;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (ALU_Select)
            OpAnd:  alu_res = data1 & data2;
            OpOr:   alu_res = data1 | data2;
            OpAdd: begin
                alu_res   = sum[N-1:0];
                alu_carry = sum[N];
                alu_ovf   = (data1[N-1] == data2[N-1]) && (sum[N-1] != data1[N-1]);
            end
            OpSub: begin
                alu_res   = diff;
                alu_carry = (data1 >= data2);
                alu_ovf   = (data1[N-1] != data2[N-1]) && (diff[N-1] != data1[N-1]);
            end
            OpPass: alu_res = data2;
            OpNor:  alu_res = ~(data1 | data2);
            OpSlt:  alu_res = {{(N - 1){1'b0}}, ($signed(data1) < $signed(data2))};
            OpSltu: alu_res = {{(N - 1){1'b0}}, (data1 < data2)};
            default: ;
        endcase
        alu_zero = (alu_res == '0);
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
`ifdef ALU_MC_MUL_EN
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
`endif

        case (state_q)
            StIdle: ;
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
`ifdef ALU_MC_MUL_EN
            StBusy: begin
                hi_d  = mul_hi_nx;
                lo_d  = mul_lo_nx;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    state_d    = StDone;
                    result_d   = mul_lo_nx;
                    zero_d     = (mul_lo_nx == '0);
                    carry_d    = |mul_hi_nx;
                    overflow_d = 1'b0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // A new acceptance overrides the IDLE/DONE decisions above
`ifdef ALU_MC_MUL_EN
        if (accept && (ALU_Select == OpMul)) begin
            state_d = StBusy;
            mcand_d = data1;
            hi_d    = '0;
            lo_d    = data2;
            cnt_d   = '0;
        end else
`endif
        if (accept) begin
            state_d    = StDone;
            result_d   = alu_res;
            zero_d     = alu_zero;
            carry_d    = alu_carry;
            overflow_d = alu_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
`ifdef ALU_MC_MUL_EN
            mcand_q    <= mcand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc (N=64) against an arithmetic reference model.
// Follows ALU_MC_MUL_EN so the model matches the build being tested.
module tb_alu_mc;

    localparam int unsigned N = 64;
`ifdef ALU_MC_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] data1;
    logic [N-1:0] data2;
    logic [3:0]   ALU_Select;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    alu_mc #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data1      (data1),
        .data2      (data2),
        .ALU_Select (ALU_Select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: each opcode's meaning computed with wide plain arithmetic
    task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic z, output logic c,
                         output logic v, output int lat);
        logic [64:0]         wide;
        logic signed [64:0]  sw;
        logic [127:0]        prod;
        r   = 64'd0;
        c   = 1'b0;
        v   = 1'b0;
        lat = 1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                wide = 65'(a) + 65'(b);
                r    = wide[63:0];
                c    = wide[64];
                sw   = $signed({a[63], a}) + $signed({b[63], b});
                v    = (sw > 65'sd9223372036854775807) || (sw < -65'sd9223372036854775808);
            end
            4'b0110: begin
                r  = a - b;
                c  = (a >= b);
                sw = $signed({a[63], a}) - $signed({b[63], b});
                v  = (sw > 65'sd9223372036854775807) || (sw < -65'sd9223372036854775808);
            end
            4'b0111: r = b;
            4'b1100: r = ~(a | b);
            4'b1000: r = (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
            4'b1001: r = (a < b) ? 64'd1 : 64'd0;
            4'b1010: begin
                if (MulEn) begin
                    prod = 128'(a) * 128'(b);
                    r    = prod[63:0];
                    c    = (prod[127:64] != 128'd0);
                    lat  = N + 1;
                end
            end
            default: ;
        endcase
        z = (r == 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one request from IDLE, check latency and flags, hold for `hold` cycles, then drain
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int hold);
        logic [63:0] er;
        logic        ez, ec, ev;
        int          el, lat;
        model(op, a, b, er, ez, ec, ev, el);
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        ALU_Select = op;
        data1      = a;
        data2      = b;
        lat = 0;
        while (!in_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("accept_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (lat == 10 && el > 1) check("busy_rdy", 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(el));
        check("result", result, er);
        check("zero", 64'(zero), 64'(ez));
        check("carry", 64'(carry), 64'(ec));
        check("overflow", 64'(overflow), 64'(ev));
        check("done_rdy", 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_result", result, er);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("drained", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        data1      = '0;
        data2      = '0;
        ALU_Select = 4'd0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_carry", 64'(carry), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", 64'(in_ready), 64'd1);

        // Directed corner cases
        run_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op(4'b0110, 64'd3, 64'd5, 1);
        run_op(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op(4'b1111, 64'h1234, 64'h5678, 0);
        run_op(4'b1010, 64'h1_0000_0000, 64'h1_0000_0001, 2);

        // Held result then back-to-back issue on the draining edge
        @(negedge clk);
        in_valid   = 1'b1;
        ALU_Select = 4'b0001;
        data1      = 64'hF0;
        data2      = 64'h0F;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("b2b_first_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("b2b_hold_result", result, 64'hFF);
            check("b2b_hold_rdy", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        ALU_Select = 4'b0000;
        data1      = 64'hF0;
        data2      = 64'h3C;
        #1;
        check("b2b_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("b2b_second_valid", 64'(out_valid), 64'd1);
        check("b2b_second_result", result, 64'h30);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset in the middle of an operation
        @(negedge clk);
        in_valid   = 1'b1;
        ALU_Select = MulEn ? 4'b1010 : 4'b0010;
        data1      = 64'hDEAD_BEEF;
        data2      = 64'h1234_5678;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_result", result, 64'd0);
        check("midrst_zero", 64'(zero), 64'd0);
        check("midrst_carry", 64'(carry), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rdy", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < N + 6; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_result", 64'(seen), 64'd0);
        run_op(4'b0010, 64'd2, 64'd2, 0);

        // Randomized traffic
        for (int k = 0; k < 200; k++) begin
            run_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
